// File: rtl/mem_controller.sv
// Round-robin arbiter putting NUM_CONSUMERS LSUs onto one memory read/write channel.
// Optional MEM_CTRL_STATS_EN adds saturating read/write completion counters.
module mem_controller #(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_CONSUMERS-1:0]          consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]          consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,
    input  logic [NUM_CONSUMERS-1:0]          consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]          consumer_write_ready,
    output logic                              mem_read_valid,
    output logic [ADDR_BITS-1:0]              mem_read_address,
    input  logic                              mem_read_ready,
    input  logic [DATA_BITS-1:0]              mem_read_data,
    output logic                              mem_write_valid,
    output logic [ADDR_BITS-1:0]              mem_write_address,
    output logic [DATA_BITS-1:0]              mem_write_data,
    input  logic                              mem_write_ready
`ifdef MEM_CTRL_STATS_EN
    ,
    output logic [15:0]                       stat_reads,
    output logic [15:0]                       stat_writes
`endif
);

    localparam int IDX_BITS = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    localparam logic [1:0] IDLE          = 2'd0;
    localparam logic [1:0] READ_WAITING  = 2'd1;
    localparam logic [1:0] WRITE_WAITING = 2'd2;
    localparam logic [1:0] RELAYING      = 2'd3;

    logic [1:0]          state;
    logic [IDX_BITS-1:0] rr_ptr;
    logic [IDX_BITS-1:0] cur_idx;
    logic                cur_is_read;

    logic                win_found;
    logic                win_is_read;
    logic [IDX_BITS-1:0] win_idx;
    int                  scan_idx;
    logic [IDX_BITS-1:0] next_ptr;
    logic                active_valid;

    // Scan from rr_ptr upward with wraparound; the first requester wins, read before write.
    always_comb begin
        win_found   = 1'b0;
        win_is_read = 1'b0;
        win_idx     = '0;
        scan_idx    = 0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            scan_idx = int'(rr_ptr) + k;
            if (scan_idx >= NUM_CONSUMERS) begin
                scan_idx = scan_idx - NUM_CONSUMERS;
            end
            if (!win_found && (consumer_read_valid[scan_idx] || consumer_write_valid[scan_idx])) begin
                win_found   = 1'b1;
                win_idx     = IDX_BITS'(scan_idx);
                win_is_read = consumer_read_valid[scan_idx];
            end
        end
    end

    always_comb begin
        next_ptr     = (cur_idx == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0 : cur_idx + 1'b1;
        active_valid = cur_is_read ? consumer_read_valid[cur_idx] : consumer_write_valid[cur_idx];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state                <= IDLE;
            rr_ptr               <= '0;
            cur_idx              <= '0;
            cur_is_read          <= 1'b0;
            mem_read_valid       <= 1'b0;
            mem_read_address     <= '0;
            mem_write_valid      <= 1'b0;
            mem_write_address    <= '0;
            mem_write_data       <= '0;
            consumer_read_ready  <= '0;
            consumer_write_ready <= '0;
            consumer_read_data   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        cur_idx     <= win_idx;
                        cur_is_read <= win_is_read;
                        if (win_is_read) begin
                            mem_read_valid   <= 1'b1;
                            mem_read_address <= consumer_read_address[win_idx*ADDR_BITS +: ADDR_BITS];
                            state            <= READ_WAITING;
                        end else begin
                            mem_write_valid   <= 1'b1;
                            mem_write_address <= consumer_write_address[win_idx*ADDR_BITS +: ADDR_BITS];
                            mem_write_data    <= consumer_write_data[win_idx*DATA_BITS +: DATA_BITS];
                            state             <= WRITE_WAITING;
                        end
                    end
                end
                READ_WAITING: begin
                    if (mem_read_ready) begin
                        consumer_read_data[cur_idx*DATA_BITS +: DATA_BITS] <= mem_read_data;
                        consumer_read_ready[cur_idx] <= 1'b1;
                        mem_read_valid               <= 1'b0;
                        state                        <= RELAYING;
                    end
                end
                WRITE_WAITING: begin
                    if (mem_write_ready) begin
                        consumer_write_ready[cur_idx] <= 1'b1;
                        mem_write_valid               <= 1'b0;
                        state                         <= RELAYING;
                    end
                end
                RELAYING: begin
                    // Hold ready until the served consumer withdraws its request.
                    if (!active_valid) begin
                        if (cur_is_read) begin
                            consumer_read_ready[cur_idx] <= 1'b0;
                        end else begin
                            consumer_write_ready[cur_idx] <= 1'b0;
                        end
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_CTRL_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_reads  <= '0;
            stat_writes <= '0;
        end else begin
            if (state == READ_WAITING && mem_read_ready && stat_reads != 16'hFFFF) begin
                stat_reads <= stat_reads + 16'd1;
            end
            if (state == WRITE_WAITING && mem_write_ready && stat_writes != 16'hFFFF) begin
                stat_writes <= stat_writes + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mem_controller.sv
// Scoreboard bench for mem_controller: directed consumer traffic against a small memory model.
// Define MEM_CTRL_STATS_EN to also check the statistics counters.
module tb_mem_controller;

    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [NC-1:0] consumer_read_valid;
    logic [NC*8-1:0] consumer_read_address;
    logic [NC-1:0] consumer_read_ready;
    logic [NC*8-1:0] consumer_read_data;
    logic [NC-1:0] consumer_write_valid;
    logic [NC*8-1:0] consumer_write_address;
    logic [NC*8-1:0] consumer_write_data;
    logic [NC-1:0] consumer_write_ready;
    logic          mem_read_valid;
    logic [7:0]    mem_read_address;
    logic          mem_read_ready;
    logic [7:0]    mem_read_data;
    logic          mem_write_valid;
    logic [7:0]    mem_write_address;
    logic [7:0]    mem_write_data;
    logic          mem_write_ready;
`ifdef MEM_CTRL_STATS_EN
    logic [15:0]   stat_reads;
    logic [15:0]   stat_writes;
`endif

    typedef struct {
        logic       is_write;
        int         idx;
        logic [7:0] addr;
        logic [7:0] data;
    } exp_t;

    exp_t expected_q[$];
    int   checks = 0;
    int   errors = 0;
    int   write_pulses [NC];
    logic [7:0] mem [0:255];

    mem_controller #(.NUM_CONSUMERS(NC), .ADDR_BITS(8), .DATA_BITS(8)) dut (
        .clk(clk),
        .reset(reset),
        .consumer_read_valid(consumer_read_valid),
        .consumer_read_address(consumer_read_address),
        .consumer_read_ready(consumer_read_ready),
        .consumer_read_data(consumer_read_data),
        .consumer_write_valid(consumer_write_valid),
        .consumer_write_address(consumer_write_address),
        .consumer_write_data(consumer_write_data),
        .consumer_write_ready(consumer_write_ready),
        .mem_read_valid(mem_read_valid),
        .mem_read_address(mem_read_address),
        .mem_read_ready(mem_read_ready),
        .mem_read_data(mem_read_data),
        .mem_write_valid(mem_write_valid),
        .mem_write_address(mem_write_address),
        .mem_write_data(mem_write_data),
        .mem_write_ready(mem_write_ready)
`ifdef MEM_CTRL_STATS_EN
        ,
        .stat_reads(stat_reads),
        .stat_writes(stat_writes)
`endif
    );

    always #5 clk = ~clk;

    // Memory model: preloaded contents restored on reset, combinational read.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int a = 0; a < 256; a++) mem[a] <= 8'd0;
            mem[10] <= 8'd5;
            mem[11] <= 8'd6;
            mem[12] <= 8'd9;
            mem[13] <= 8'd3;
        end else if (mem_write_valid && mem_write_ready) begin
            mem[mem_write_address] <= mem_write_data;
        end
    end

    assign mem_read_data = mem[mem_read_address];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_mem_read_valid"}, 32'(mem_read_valid), 0);
        checkOutput({tag, "_mem_write_valid"}, 32'(mem_write_valid), 0);
        checkOutput({tag, "_mem_addrs"}, {16'd0, mem_read_address, mem_write_address}, 0);
        checkOutput({tag, "_mem_write_data"}, 32'(mem_write_data), 0);
        checkOutput({tag, "_readys"}, {24'd0, consumer_read_ready, consumer_write_ready}, 0);
        checkOutput({tag, "_read_data"}, consumer_read_data, 0);
    endtask

    task automatic pushExp(input logic is_write, input int idx, input logic [7:0] addr, input logic [7:0] data);
        exp_t e;
        e.is_write = is_write;
        e.idx      = idx;
        e.addr     = addr;
        e.data     = data;
        expected_q.push_back(e);
    endtask

    // One full consumer handshake: raise valid, wait for ready, drop valid, wait for ready to clear.
    task automatic applyStimulus(input logic is_write, input int idx, input logic [7:0] addr, input logic [7:0] data);
        logic done;
        @(negedge clk);
        if (is_write) begin
            consumer_write_valid[idx]            = 1'b1;
            consumer_write_address[idx*8 +: 8]   = addr;
            consumer_write_data[idx*8 +: 8]      = data;
        end else begin
            consumer_read_valid[idx]             = 1'b1;
            consumer_read_address[idx*8 +: 8]    = addr;
        end
        done = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            done = is_write ? consumer_write_ready[idx] : consumer_read_ready[idx];
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_timeout consumer %0d write=%0b: got no ready, expected ready within 200 cycles", idx, is_write);
        end
        if (is_write) consumer_write_valid[idx] = 1'b0;
        else          consumer_read_valid[idx]  = 1'b0;
        done = 1'b0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            done = is_write ? !consumer_write_ready[idx] : !consumer_read_ready[idx];
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_release consumer %0d: got ready stuck high, expected low", idx);
        end
    endtask

    initial begin
        exp_t e;
        logic prev_mrv, prev_mwv;
        logic [NC-1:0] prev_rr, prev_wr;
        logic [7:0] last_rd_addr, last_wr_addr, last_wr_data;

        reset                  = 1'b1;
        consumer_read_valid    = '0;
        consumer_read_address  = '0;
        consumer_write_valid   = '0;
        consumer_write_address = '0;
        consumer_write_data    = '0;
        mem_read_ready         = 1'b1;
        mem_write_ready        = 1'b1;
        prev_mrv = 1'b0; prev_mwv = 1'b0; prev_rr = '0; prev_wr = '0;
        last_rd_addr = '0; last_wr_addr = '0; last_wr_data = '0;
        for (int i = 0; i < NC; i++) write_pulses[i] = 0;

        // Monitor: every ready rising edge is a completion matched against the scoreboard.
        fork
            forever begin
                @(negedge clk);
                checkOutput("one_mem_valid", 32'(mem_read_valid & mem_write_valid), 0);
                if (mem_read_valid && !prev_mrv) last_rd_addr = mem_read_address;
                if (mem_write_valid && !prev_mwv) begin
                    last_wr_addr = mem_write_address;
                    last_wr_data = mem_write_data;
                end
                for (int i = 0; i < NC; i++) begin
                    if (consumer_write_ready[i] && !prev_wr[i]) write_pulses[i]++;
                    if ((consumer_read_ready[i] && !prev_rr[i]) || (consumer_write_ready[i] && !prev_wr[i])) begin
                        if (expected_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL unexpected_completion consumer %0d: got a completion, expected none", i);
                        end else begin
                            e = expected_q.pop_front();
                            checkOutput("sb_idx", i, e.idx);
                            if (consumer_read_ready[i] && !prev_rr[i]) begin
                                checkOutput("sb_kind", 0, 32'(e.is_write));
                                checkOutput("sb_rd_addr", 32'(last_rd_addr), 32'(e.addr));
                                checkOutput("sb_rd_data", 32'(consumer_read_data[i*8 +: 8]), 32'(e.data));
                            end else begin
                                checkOutput("sb_kind", 1, 32'(e.is_write));
                                checkOutput("sb_wr_addr", 32'(last_wr_addr), 32'(e.addr));
                                checkOutput("sb_wr_data", 32'(last_wr_data), 32'(e.data));
                            end
                        end
                    end
                end
                prev_mrv = mem_read_valid;
                prev_mwv = mem_write_valid;
                prev_rr  = consumer_read_ready;
                prev_wr  = consumer_write_ready;
            end
        join_none

        repeat (2) @(negedge clk);
        checkAllZero("reset");
        reset = 1'b0;

        // Single read with explicit latency checks.
        pushExp(1'b0, 0, 8'd10, 8'd5);
        @(negedge clk);
        consumer_read_valid[0] = 1'b1;
        consumer_read_address[7:0] = 8'd10;
        @(posedge clk); #1;
        checkOutput("single_mem_read_valid", 32'(mem_read_valid), 1);
        checkOutput("single_mem_read_addr", 32'(mem_read_address), 10);
        checkOutput("single_ready_early", 32'(consumer_read_ready[0]), 0);
        @(posedge clk); #1;
        checkOutput("single_ready", 32'(consumer_read_ready[0]), 1);
        checkOutput("single_data", 32'(consumer_read_data[7:0]), 5);
        checkOutput("single_mem_valid_low", 32'(mem_read_valid), 0);
        @(negedge clk);
        consumer_read_valid[0] = 1'b0;
        @(posedge clk); #1;
        checkOutput("single_ready_clear", 32'(consumer_read_ready[0]), 0);

        // Write then read from consumer 2.
        pushExp(1'b1, 2, 8'd16, 8'd12);
        pushExp(1'b0, 2, 8'd16, 8'd12);
        applyStimulus(1'b1, 2, 8'd16, 8'd12);
        applyStimulus(1'b0, 2, 8'd16, 8'd0);
        checkOutput("write_pulse_count", write_pulses[2], 1);
`ifdef MEM_CTRL_STATS_EN
        checkOutput("stat_reads_a", 32'(stat_reads), 2);
        checkOutput("stat_writes_a", 32'(stat_writes), 1);
`endif

        // Round robin from reset: all four consumers at once.
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        pushExp(1'b0, 0, 8'd10, 8'd5);
        pushExp(1'b0, 1, 8'd11, 8'd6);
        pushExp(1'b0, 2, 8'd12, 8'd9);
        pushExp(1'b0, 3, 8'd13, 8'd3);
        fork
            applyStimulus(1'b0, 0, 8'd10, 8'd0);
            applyStimulus(1'b0, 1, 8'd11, 8'd0);
            applyStimulus(1'b0, 2, 8'd12, 8'd0);
            applyStimulus(1'b0, 3, 8'd13, 8'd0);
        join

        // Two continuous requesters must alternate.
        for (int r = 0; r < 3; r++) begin
            pushExp(1'b0, 0, 8'd10, 8'd5);
            pushExp(1'b0, 1, 8'd11, 8'd6);
        end
        fork
            begin repeat (3) applyStimulus(1'b0, 0, 8'd10, 8'd0); end
            begin repeat (3) applyStimulus(1'b0, 1, 8'd11, 8'd0); end
        join

        // Backpressure: request held, address change after grant ignored.
        pushExp(1'b0, 3, 8'd12, 8'd9);
        @(negedge clk);
        mem_read_ready = 1'b0;
        consumer_read_valid[3] = 1'b1;
        consumer_read_address[31:24] = 8'd12;
        @(posedge clk); #1;
        checkOutput("bp_mem_read_valid", 32'(mem_read_valid), 1);
        @(negedge clk);
        consumer_read_address[31:24] = 8'd99;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("bp_valid_stable", 32'(mem_read_valid), 1);
            checkOutput("bp_addr_stable", 32'(mem_read_address), 12);
            checkOutput("bp_no_ready", 32'(consumer_read_ready[3]), 0);
        end
        mem_read_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("bp_ready", 32'(consumer_read_ready[3]), 1);
        checkOutput("bp_data", 32'(consumer_read_data[31:24]), 9);
        @(negedge clk);
        consumer_read_valid[3] = 1'b0;
        @(negedge clk);
        checkOutput("bp_ready_clear", 32'(consumer_read_ready[3]), 0);

        // Read wins over write for the same consumer; write follows on its next grant.
        pushExp(1'b0, 1, 8'd11, 8'd6);
        pushExp(1'b1, 1, 8'd20, 8'd77);
        fork
            applyStimulus(1'b0, 1, 8'd11, 8'd0);
            applyStimulus(1'b1, 1, 8'd20, 8'd77);
        join
        checkOutput("prio_mem_written", 32'(mem[20]), 77);
        checkOutput("hold_read_data_c0", 32'(consumer_read_data[7:0]), 5);
`ifdef MEM_CTRL_STATS_EN
        checkOutput("stat_reads_b", 32'(stat_reads), 12);
        checkOutput("stat_writes_b", 32'(stat_writes), 1);
`endif

        // Reset while a read is outstanding; arbitration restarts at consumer 0.
        @(negedge clk);
        mem_read_ready = 1'b0;
        consumer_read_valid[2] = 1'b1;
        consumer_read_address[23:16] = 8'd13;
        @(posedge clk); #1;
        checkOutput("midop_mem_read_valid", 32'(mem_read_valid), 1);
        #2 reset = 1'b1;
        #1;
        checkAllZero("midop");
`ifdef MEM_CTRL_STATS_EN
        checkOutput("midop_stats", {stat_reads, stat_writes}, 0);
`endif
        @(negedge clk);
        reset = 1'b0;
        consumer_read_valid[2] = 1'b0;
        mem_read_ready = 1'b1;
        pushExp(1'b0, 0, 8'd10, 8'd5);
        pushExp(1'b0, 3, 8'd13, 8'd3);
        fork
            applyStimulus(1'b0, 3, 8'd13, 8'd0);
            applyStimulus(1'b0, 0, 8'd10, 8'd0);
        join

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", expected_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
